// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that time-shares one combinational 8-bit ALU among NREQ
// requesters and returns each result, tagged with the requester ID, over a valid/ready channel.
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [2*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [1:0]        alu_op,
    input  logic [7:0]        alu_result,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDW-1:0]  r_ptr;
    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [1:0]      r_alu_op;
    logic [7:0]      r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;

    logic            w_hi_any;
    logic [IDW-1:0]  w_hi_id;
    logic            w_lo_any;
    logic [IDW-1:0]  w_lo_id;
    logic            w_grant_any;
    logic [IDW-1:0]  w_grant_id;
    logic            w_accept;
    logic [IDW-1:0]  w_ptr_next;
    logic [7:0]      w_sel_a;
    logic [7:0]      w_sel_b;
    logic [1:0]      w_sel_op;
    logic [NREQ-1:0] w_req_ready;

    // Two priority passes: lowest requester at or above the pointer wins,
    // otherwise the lowest requester overall (the wrap-around part of the ring).
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_id  = '0;
        w_lo_any = 1'b0;
        w_lo_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo_id  = IDW'(i);
                if (IDW'(i) >= r_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_id  = IDW'(i);
                end
            end
        end
        w_grant_any = w_lo_any;
        w_grant_id  = w_hi_any ? w_hi_id : w_lo_id;
    end

    assign w_accept   = (r_state == IDLE) && w_grant_any && !rst;
    assign w_ptr_next = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);

    always_comb begin
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_op    = '0;
        w_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == IDW'(i)) begin
                w_sel_a        = req_a[i*8 +: 8];
                w_sel_b        = req_b[i*8 +: 8];
                w_sel_op       = req_op[i*2 +: 2];
                w_req_ready[i] = w_accept;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands are latched on the accept edge and held until the next accept,
    // so the ALU inputs only move when a new operation starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_ptr    <= w_ptr_next;
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
                r_rsp_id <= w_grant_id;
            end
            if (r_state == EXEC) begin
                r_rsp_data <= alu_result;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: an ALU stub closes the loop and a
// scoreboard queue is drained by a monitor on every response handshake.
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [1:0]        alu_op;
    logic [7:0]        alu_result;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int         exp_id_q[$];
    logic [7:0] exp_d_q[$];
    int         mon_id;
    logic [7:0] mon_d;

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a & alu_b;
            2'b10:   alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_op[i*2 +: 2] = op;
        req_valid[i]     = 1'b1;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_id_q.push_back(id);
        exp_d_q.push_back(d);
    endtask

    task automatic wait_grant();
        int n = 0;
        #1;
        while (req_ready == '0 && n < 12) begin
            tick();
            n++;
        end
        if (n >= 12) chk("grant_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_d_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_d_q.size()), 0);
    endtask

    // Monitor: any visible response must be expected; a handshake pops and compares.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_d_q.size() == 0) begin
                chk("spurious_rsp", 32'(rsp_valid), 0);
            end else if (rsp_ready) begin
                mon_d  = exp_d_q.pop_front();
                mon_id = exp_id_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(mon_d));
                chk("rsp_id", 32'(rsp_id), 32'(mon_id));
            end
        end
    end

    initial begin
        logic [7:0] rr_exp [4];
        int prev;
        rr_exp = '{8'h76, 8'h88, 8'hEE, 8'h66};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_ctrl", 32'({busy, rsp_valid, req_ready, rsp_id}), 0);
        chk("reset_data", 32'({alu_a, alu_b, alu_op, rsp_data}), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("idle_after_reset", 32'({busy, req_ready}), 0);

        // single request with response back-pressure
        set_req(1, 8'hCC, 8'hAA, 2'b00);
        #1;
        chk("single_ready", 32'(req_ready), 'h2);
        push(1, 8'h76);
        tick();
        req_valid = '0;
        chk("single_ready_off", 32'(req_ready), 0);
        chk("single_operands", 32'({alu_a, alu_b, alu_op}), 32'({8'hCC, 8'hAA, 2'b00}));
        chk("single_busy", 32'(busy), 1);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 1);
        chk("single_rsp", 32'({rsp_data, 6'd0, rsp_id}), 32'({8'h76, 6'd0, 2'd1}));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("single_hold", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'h76}));
        end
        rsp_ready = 1'b1;
        tick();
        chk("single_release", 32'({rsp_valid, busy}), 0);

        // round robin: pointer back to 0 via reset, all four requesters pending
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 8'hCC, 8'hAA, 2'(i));
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant();
            chk("rr_grant", 32'(req_ready), 32'(1 << g));
            if (g > 0) chk("rr_spacing", 32'(cyc - prev), 3);
            prev = cyc;
            push(g, rr_exp[g]);
            tick();
            req_valid[g] = 1'b0;
        end
        drain();

        // pointer wrap: move pointer to 3, then requesters 3 and 0 compete
        set_req(2, 8'h10, 8'h05, 2'b00);
        wait_grant();
        chk("wrap_pre_grant", 32'(req_ready), 'h4);
        push(2, 8'h15);
        tick();
        req_valid = '0;
        set_req(3, 8'hF0, 8'h0F, 2'b10);
        set_req(0, 8'h81, 8'h80, 2'b00);
        wait_grant();
        chk("wrap_first", 32'(req_ready), 'h8);
        push(3, 8'hFF);
        tick();
        req_valid[3] = 1'b0;
        wait_grant();
        chk("wrap_second", 32'(req_ready), 'h1);
        push(0, 8'h01);
        tick();
        req_valid = '0;
        set_req(0, 8'h81, 8'h80, 2'b00);
        set_req(1, 8'h3C, 8'h0F, 2'b01);
        set_req(3, 8'hF0, 8'h0F, 2'b10);
        wait_grant();
        chk("wrap_ptr_at_1", 32'(req_ready), 'h2);
        push(1, 8'h0C);
        tick();
        req_valid = '0;
        drain();

        // reset while in EXEC aborts the operation
        set_req(0, 8'h5A, 8'hA5, 2'b11);
        wait_grant();
        chk("abort_grant", 32'(req_ready), 'h1);
        tick();
        chk("abort_exec", 32'({busy, alu_a}), 32'({1'b1, 8'h5A}));
        #2 rst = 1'b1;
        #1;
        chk("abort_reset", 32'({busy, rsp_valid, req_ready, alu_a}), 0);
        req_valid = '0;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort_no_rsp", 32'({busy, rsp_valid}), 0);

        // late arrival while a response is back-pressured
        rsp_ready = 1'b0;
        set_req(1, 8'h22, 8'h11, 2'b11);
        wait_grant();
        chk("late_first_grant", 32'(req_ready), 'h2);
        push(1, 8'h33);
        tick();
        req_valid = '0;
        tick();
        chk("late_in_resp", 32'(rsp_valid), 1);
        set_req(2, 8'h40, 8'h04, 2'b10);
        #1;
        chk("late_no_ready_a", 32'(req_ready), 0);
        tick();
        chk("late_no_ready_b", 32'(req_ready), 0);
        rsp_ready = 1'b1;
        #1;
        chk("late_no_ready_hs", 32'(req_ready), 0);
        tick();
        rsp_ready = 1'b0;
        chk("late_grant", 32'(req_ready), 'h4);
        push(2, 8'h44);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one 8-bit combinational ALU between NREQ requesters using round-robin arbitration. The scheduler accepts one operation at a time and holds the operands and opcode in registers while the ALU evaluates. It returns the registered result with the requester ID over a valid/ready response channel. It sits between the requester blocks and the shared 8-bit ALU, which it drives and whose result it samples.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester-ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operation-pending flag
req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i]
req_b  input  8*NREQ  operand B, packed the same way as req_a
req_op  input  2*NREQ  ALU opcode; requester i uses bits [2i+1:2i]
req_ready  output  NREQ  one-hot accept pulse; a transfer occurs when req_valid[i] and req_ready[i] are both high
alu_a  output  8  registered operand A to the ALU
alu_b  output  8  registered operand B to the ALU
alu_op  output  2  registered opcode to the ALU
alu_result  input  8  combinational ALU output
rsp_valid  output  1  response holding
rsp_data  output  8  captured ALU result
rsp_id  output  IDW  index of the requester that owns the response
rsp_ready  input  1  response consumer accepts
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately) clears all outputs and state:
  - state = IDLE
  - req_ready = 0, rsp_valid = 0, busy = 0
  - alu_a = alu_b = 8'h00, alu_op = 2'b00
  - rsp_data = 8'h00, rsp_id = 0
  - round-robin pointer ptr = 0
- FSM states and transitions:
  - IDLE to EXEC:
    - When any req_valid bit is high, grant g = the first set bit searching from ptr upward, wrapping modulo NREQ.
    - req_ready[g] is asserted combinationally in IDLE, so the transfer completes in this same cycle.
    - On the clock edge: alu_a, alu_b and alu_op load requester g's fields, rsp_id loads g, and ptr loads (g+1) mod NREQ.
  - EXEC to RESP:
    - This lasts exactly one cycle; alu_* stay stable.
    - On the edge: rsp_data captures alu_result, and rsp_valid goes to 1.
  - RESP to IDLE:
    - rsp_valid, rsp_data and rsp_id hold until rsp_ready is sampled high.
    - On that edge rsp_valid goes to 0.
- req_ready is 0 in EXEC and RESP; at most one bit is ever high.
- A new grant in the cycle that rsp_ready is accepted is not allowed. Accept-to-accept spacing is therefore at least 3 cycles.
- Latency: the response becomes valid 2 edges after the accept edge.
- alu_* keep their last values in IDLE and RESP; they do not return to zero.
- Requester-side rules:
  - A requester may drop req_valid before it is granted; no state changes.
  - Its fields are sampled only on its own accept edge.
- Fairness: a requester that holds req_valid continuously is served within NREQ grants.
- Reset in the middle of an operation (EXEC or RESP) aborts it. No response is produced for that operation; the block returns to the IDLE reset values.
- Arithmetic and flags are entirely the ALU's responsibility. The scheduler does no width extension and has no carry or flag handling.

Test Plan:
- Bench uses an ALU stub: op 00 gives a+b mod 256, 01 gives a&b, 10 gives a|b, 11 gives a^b.
- Reset sequence: assert rst mid-cycle with no clock edge -> every output reads 0 immediately. Release rst -> block stays IDLE with busy=0.
- Single request: req 1 only, A=8'hCC, B=8'hAA, op=00 -> req_ready=4'b0010 for one cycle; alu_a/alu_b/alu_op = CC/AA/00 after the accept edge; rsp_valid 2 edges after accept with rsp_data=8'h76, rsp_id=1. With rsp_ready held low for 3 cycles the response holds; raising it returns the block to IDLE.
- Round-robin: all four requesters valid with A=CC, B=AA and ops 00/01/10/11 respectively, rsp_ready tied 1 -> grant order 0,1,2,3. Responses in order: 76/0, 88/1, EE/2, 66/3. Accepts are spaced exactly 3 cycles apart.
- Pointer wrap: requesters 3 and 0 valid with ptr=3 -> requester 3 is granted first, then requester 0, and ptr ends at 1.
- Reset during operation: assert rst while in EXEC -> no rsp_valid pulse is produced; busy=0 and alu_a=8'h00 immediately.
- Back-pressure with a late arrival: requester 2 raises req_valid while the block is in RESP -> requester 2 gets no req_ready until the cycle after the rsp_ready handshake.
